// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - op encodings, FSM states and constants for the iterative M-extension unit
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } md_state_e;

  localparam int          ITER   = 32;
  localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_Q  = 32'h8000_0000;

endpackage

// File: rtl/ex_muldiv_sign_adjust.sv
// rtl/ex_muldiv_sign_adjust.sv - operand magnitude conversion on entry, sign restoration on exit
module muldiv_sign_adjust
  import ex_muldiv_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] mag_a_o,
  output logic [31:0] mag_b_o,
  output logic        sign_a_o,
  output logic        sign_b_o,
  input  logic [63:0] prod_mag_i,
  input  logic [31:0] quot_mag_i,
  input  logic [31:0] rem_mag_i,
  input  logic        neg_res_i,
  input  logic        neg_rem_i,
  output logic [63:0] prod_o,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic a_signed;
  logic b_signed;

  // MULHSU treats only rs1 as signed
  assign a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);

  assign sign_a_o = a_signed & a_i[31];
  assign sign_b_o = b_signed & b_i[31];
  assign mag_a_o  = sign_a_o ? (32'd0 - a_i) : a_i;
  assign mag_b_o  = sign_b_o ? (32'd0 - b_i) : b_i;

  assign prod_o = neg_res_i ? (64'd0 - prod_mag_i) : prod_mag_i;
  assign quot_o = neg_res_i ? (32'd0 - quot_mag_i) : quot_mag_i;
  assign rem_o  = neg_rem_i ? (32'd0 - rem_mag_i) : rem_mag_i;

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - fixed-latency radix-2 multiply/divide unit for the EX stage
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  md_state_e   state_q, state_d;
  md_op_e      op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic [31:0] result_q, result_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  logic        ovf_q, ovf_d;

  logic [31:0] mag_a, mag_b;
  logic        sign_a, sign_b;
  logic [63:0] prod_fin;
  logic [31:0] quot_fin, rem_fin;
  logic [32:0] mul_sum, div_top, div_diff;
  logic [63:0] step;
  logic [31:0] fin;

  muldiv_sign_adjust u_sign_adjust (
    .op_i       (op),
    .a_i        (op_a),
    .b_i        (op_b),
    .mag_a_o    (mag_a),
    .mag_b_o    (mag_b),
    .sign_a_o   (sign_a),
    .sign_b_o   (sign_b),
    .prod_mag_i (step),
    .quot_mag_i (step[31:0]),
    .rem_mag_i  (step[63:32]),
    .neg_res_i  (neg_res_q),
    .neg_rem_i  (neg_rem_q),
    .prod_o     (prod_fin),
    .quot_o     (quot_fin),
    .rem_o      (rem_fin)
  );

  // acc = {hi, lo}: multiply shifts right adding into hi; divide shifts left, hi is the partial remainder
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    div_top  = acc_q[63:31];
    div_diff = div_top - {1'b0, b_q};
    if (op_q[2]) begin
      step = div_diff[32] ? {div_top[31:0], acc_q[30:0], 1'b0}
                          : {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      step = {mul_sum, acc_q[31:1]};
    end
  end

  always_comb begin
    case (op_q)
      OP_MUL:                       fin = prod_fin[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin = prod_fin[63:32];
      OP_DIV, OP_DIVU:              fin = div0_q ? DIV0_Q : (ovf_q ? OVF_Q : quot_fin);
      default:                      fin = div0_q ? a_q : (ovf_q ? 32'd0 : rem_fin);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    rd_out_d  = rd_out_q;
    result_d  = result_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: busy = start && !flush;
      S_CALC: busy = 1'b1;
      S_DONE: done = 1'b1;
      default: ;
    endcase

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d      = md_op_e'(op);
            a_d       = op_a;
            b_d       = mag_b;
            acc_d     = {32'd0, mag_a};
            cnt_d     = 5'd0;
            rd_d      = rd_in;
            neg_res_d = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            div0_d    = (op_b == 32'd0);
            ovf_d     = ((op == OP_DIV) || (op == OP_REM)) &&
                        (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
            state_d   = S_CALC;
          end
        end
        S_CALC: begin
          acc_d = step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(ITER - 1)) begin
            result_d = fin;
            rd_out_d = rd_q;
            state_d  = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MUL;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      acc_q     <= 64'd0;
      cnt_q     <= 5'd0;
      rd_q      <= 5'd0;
      rd_out_q  <= 5'd0;
      result_q  <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      rd_out_q  <= rd_out_d;
      result_q  <= result_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
    end
  end

  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  EX stage presents a valid M-extension op this cycle.
REQ-005 op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  in  32  rs1 operand, after forwarding.
REQ-007 op_b  in  32  rs2 operand, after forwarding.
REQ-008 rd_in  in  5  destination register of the op.
REQ-009 flush  in  1  abort the op in flight (branch/jalr redirect).
REQ-010 busy  out  1  stall request to the hazard unit; holds the IF/ID and ID/EX enables low.
REQ-011 done  out  1  one-cycle pulse; result and rd_out are valid.
REQ-012 result  out  32  selected product half, quotient or remainder.
REQ-013 rd_out  out  5  latched copy of rd_in for the op.

Function
REQ-014 States SHALL be IDLE, CALC and DONE.
REQ-015 IDLE with start=1 and flush=0 SHALL latch op, op_a, op_b and rd_in, load iteration counter to 0, and go to CALC.
REQ-016 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring subtract for divide.
REQ-017 CALC SHALL go to DONE after exactly 32 steps, when counter=31.
REQ-018 DONE SHALL assert done=1 for one cycle and then return to IDLE.
REQ-019 Latency SHALL be fixed: done is asserted 33 cycles after the start cycle, for every op including special cases.
REQ-020 busy SHALL equal (IDLE and start and not flush) or CALC; busy=0 in DONE so the ID/EX register captures the next instruction.
REQ-021 Operands SHALL be converted to magnitudes before iterating:
 - signed for MULH, DIV and REM (both operands);
 - op_a only for MULHSU;
 - none for the unsigned ops.
REQ-022 The final sign SHALL be applied in the last step:
 - product sign = sign(a) xor sign(b);
 - quotient sign = sign(a) xor sign(b);
 - remainder sign = sign(a).
REQ-023 Result select SHALL be: MUL low 32 bits of the 64-bit product; MULH, MULHSU and MULHU high 32 bits.
REQ-024 Divide-by-zero SHALL return quotient 0xFFFFFFFF and remainder = op_a, for both signed and unsigned divides.
REQ-025 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL return quotient 0x80000000 and remainder 0.
REQ-026 start while in CALC or DONE SHALL be ignored; the hazard unit holds EX stalled, so this does not occur legally.
REQ-027 flush in any state SHALL force IDLE on the next edge, with no done pulse.
REQ-028 flush has priority over start in the same cycle.
REQ-029 result and rd_out SHALL hold their last value outside DONE.

Reset
REQ-030 rst=1 SHALL on the next edge force IDLE and set busy=0, done=0, result=0, rd_out=0, counter=0, and all internal operand and accumulator registers to 0.
REQ-031 rst SHALL have priority over flush and start.
REQ-032 rst asserted mid-CALC SHALL abandon the op with no done pulse.

Structure
REQ-033 A shared package SHALL hold:
 - the op encodings;
 - the state enum;
 - ITER=32;
 - the constants DIV0_Q=0xFFFFFFFF and OVF_Q=0x80000000.
REQ-034 One sub-module, muldiv_sign_adjust, SHALL provide the combinational magnitude conversion and final negation.
REQ-035 The datapath SHALL use one 64-bit accumulator shared by the multiply and divide paths.

Verification
REQ-036 MUL 7 x -3 (0x00000007, 0xFFFFFFFD): done 33 cycles after start, result 0xFFFFFFEB, busy high for exactly 33 cycles starting at the start cycle.
REQ-037 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULH of the same operands -> result 0x00000000.
REQ-038 DIV -7/2 -> result 0xFFFFFFFD; REM -7/2 -> result 0xFFFFFFFF; DIVU 5/0 -> result 0xFFFFFFFF; REM 5/0 -> result 5.
REQ-039 DIV 0x80000000/0xFFFFFFFF -> result 0x80000000; REM of the same operands -> result 0.
REQ-040 flush at CALC step 10 -> IDLE next cycle, busy=0, no done; a new start next cycle completes normally with the correct rd_out.
REQ-041 rst at CALC step 20 -> all outputs 0 the next cycle, no done; start asserted together with rst is ignored.
